// File: rtl/rf_pkg.sv
// Shared widths and types for the ID-stage register file and its write scoreboard.
package rf_pkg;

    localparam int XLEN      = 32;
    localparam int NUM_REGS  = 32;
    localparam int REG_IDX_W = 5;
    localparam int CNT_W     = 2;

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [XLEN-1:0]      xword_t;
    typedef logic [CNT_W-1:0]     sb_cnt_t;

    localparam sb_cnt_t CNT_MAX = '1;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register outstanding-write counters; raises Stall on RAW hazards and
// records a sticky overflow when an issue hits a saturated counter.
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     IssueValid,
    input  logic     IssueRegWrite,
    input  reg_idx_t IssueRd,
    input  logic     RegWrite_ID,
    input  reg_idx_t WriteRegister_ID,
    input  reg_idx_t ReadReg1,
    input  reg_idx_t ReadReg2,
    input  logic     UsesRs1,
    input  logic     UsesRs2,
    output logic     Stall,
    output logic     SbOverflow
);

    sb_cnt_t cnt_q [NUM_REGS];
    sb_cnt_t cnt_d [NUM_REGS];
    logic    overflow_q, overflow_d;

    logic                busy1, busy2;
    logic                wbHits1, wbHits2;
    logic                issueFire;
    logic [NUM_REGS-1:0] incVec, decVec;

    // A writeback retiring the last outstanding write clears the hazard in the same cycle.
    always_comb begin
        wbHits1 = RegWrite_ID && (WriteRegister_ID == ReadReg1);
        wbHits2 = RegWrite_ID && (WriteRegister_ID == ReadReg2);
        busy1   = (ReadReg1 != '0) && (cnt_q[ReadReg1] != '0) &&
                  !(wbHits1 && (cnt_q[ReadReg1] == sb_cnt_t'(1)));
        busy2   = (ReadReg2 != '0) && (cnt_q[ReadReg2] != '0) &&
                  !(wbHits2 && (cnt_q[ReadReg2] == sb_cnt_t'(1)));
    end

    assign Stall      = IssueValid && ((UsesRs1 && busy1) || (UsesRs2 && busy2));
    assign issueFire  = IssueValid && !Stall;
    assign SbOverflow = overflow_q;

    always_comb begin
        incVec = '0;
        decVec = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            incVec[r] = issueFire && IssueRegWrite && (IssueRd == reg_idx_t'(r));
            decVec[r] = RegWrite_ID && (WriteRegister_ID == reg_idx_t'(r)) &&
                        (cnt_q[r] != '0);
        end
    end

    // Writebacks to an idle counter are untracked and leave it at zero.
    always_comb begin
        overflow_d = overflow_q;
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        for (int r = 1; r < NUM_REGS; r++) begin
            if (incVec[r] && !decVec[r]) begin
                if (cnt_q[r] == CNT_MAX) begin
                    overflow_d = 1'b1;
                end else begin
                    cnt_d[r] = cnt_q[r] + sb_cnt_t'(1);
                end
            end else if (decVec[r] && !incVec[r]) begin
                cnt_d[r] = cnt_q[r] - sb_cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            overflow_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/id_regfile_sb.sv
// ID-stage 32x32 register file with write-to-read bypass and an in-flight
// write scoreboard that stalls issue on RAW hazards.
module id_regfile_sb
    import rf_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     RegWrite_ID,
    input  reg_idx_t WriteRegister_ID,
    input  xword_t   WriteData_ID,
    input  reg_idx_t ReadReg1,
    input  reg_idx_t ReadReg2,
    input  logic     UsesRs1,
    input  logic     UsesRs2,
    input  logic     IssueValid,
    input  logic     IssueRegWrite,
    input  reg_idx_t IssueRd,
    output xword_t   ReadData1,
    output xword_t   ReadData2,
    output logic     Stall,
    output logic     SbOverflow
);

    xword_t regs_q [NUM_REGS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (RegWrite_ID && (WriteRegister_ID != '0)) begin
            regs_q[WriteRegister_ID] <= WriteData_ID;
        end
    end

    // x0 reads as zero; a same-cycle writeback to the source wins over storage.
    always_comb begin
        ReadData1 = regs_q[ReadReg1];
        if (ReadReg1 == '0) begin
            ReadData1 = '0;
        end else if (RegWrite_ID && (WriteRegister_ID == ReadReg1)) begin
            ReadData1 = WriteData_ID;
        end
    end

    always_comb begin
        ReadData2 = regs_q[ReadReg2];
        if (ReadReg2 == '0) begin
            ReadData2 = '0;
        end else if (RegWrite_ID && (WriteRegister_ID == ReadReg2)) begin
            ReadData2 = WriteData_ID;
        end
    end

    rf_scoreboard u_scoreboard (
        .clk              (clk),
        .reset            (reset),
        .IssueValid       (IssueValid),
        .IssueRegWrite    (IssueRegWrite),
        .IssueRd          (IssueRd),
        .RegWrite_ID      (RegWrite_ID),
        .WriteRegister_ID (WriteRegister_ID),
        .ReadReg1         (ReadReg1),
        .ReadReg2         (ReadReg2),
        .UsesRs1          (UsesRs1),
        .UsesRs2          (UsesRs2),
        .Stall            (Stall),
        .SbOverflow       (SbOverflow)
    );

endmodule

// File: tb/tb_id_regfile_sb.sv
// Scoreboard bench for id_regfile_sb: directed vectors push expectations,
// a negedge monitor pops and compares them against the live outputs.
module tb_id_regfile_sb;

    logic        clk;
    logic        reset;
    logic        RegWrite_ID;
    logic [4:0]  WriteRegister_ID;
    logic [31:0] WriteData_ID;
    logic [4:0]  ReadReg1, ReadReg2;
    logic        UsesRs1, UsesRs2;
    logic        IssueValid, IssueRegWrite;
    logic [4:0]  IssueRd;
    logic [31:0] ReadData1, ReadData2;
    logic        Stall, SbOverflow;

    typedef struct {
        string       name;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        stall;
        logic        ovf;
    } exp_t;

    exp_t expQ[$];
    int   checkCount = 0;
    int   errorCount = 0;

    id_regfile_sb dut (
        .clk              (clk),
        .reset            (reset),
        .RegWrite_ID      (RegWrite_ID),
        .WriteRegister_ID (WriteRegister_ID),
        .WriteData_ID     (WriteData_ID),
        .ReadReg1         (ReadReg1),
        .ReadReg2         (ReadReg2),
        .UsesRs1          (UsesRs1),
        .UsesRs2          (UsesRs2),
        .IssueValid       (IssueValid),
        .IssueRegWrite    (IssueRegWrite),
        .IssueRd          (IssueRd),
        .ReadData1        (ReadData1),
        .ReadData2        (ReadData2),
        .Stall            (Stall),
        .SbOverflow       (SbOverflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input string field,
                               input logic [31:0] actual, input logic [31:0] required);
        checkCount++;
        if (actual !== required) begin
            errorCount++;
            $display("[TB] FAIL %s.%s actual=%h required=%h", name, field, actual, required);
        end
    endtask

    // Monitor: each negedge, the oldest pending expectation is compared to the outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e.name, "ReadData1", ReadData1, e.rd1);
                checkOutput(e.name, "ReadData2", ReadData2, e.rd2);
                checkOutput(e.name, "Stall", {31'b0, Stall}, {31'b0, e.stall});
                checkOutput(e.name, "SbOverflow", {31'b0, SbOverflow}, {31'b0, e.ovf});
            end
        end
    end

    task automatic applyStimulus(
        input string name, input logic rst,
        input logic rw, input logic [4:0] wr, input logic [31:0] wd,
        input logic [4:0] rr1, input logic [4:0] rr2, input logic u1, input logic u2,
        input logic iv, input logic irw, input logic [4:0] ird,
        input logic [31:0] e1, input logic [31:0] e2, input logic es, input logic eo);
        exp_t e;
        reset            = rst;
        RegWrite_ID      = rw;
        WriteRegister_ID = wr;
        WriteData_ID     = wd;
        ReadReg1         = rr1;
        ReadReg2         = rr2;
        UsesRs1          = u1;
        UsesRs2          = u2;
        IssueValid       = iv;
        IssueRegWrite    = irw;
        IssueRd          = ird;
        e.name  = name;
        e.rd1   = e1;
        e.rd2   = e2;
        e.stall = es;
        e.ovf   = eo;
        expQ.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int drainBudget;
        reset = 1'b1; RegWrite_ID = 1'b0; WriteRegister_ID = '0; WriteData_ID = '0;
        ReadReg1 = '0; ReadReg2 = '0; UsesRs1 = 1'b0; UsesRs2 = 1'b0;
        IssueValid = 1'b0; IssueRegWrite = 1'b0; IssueRd = '0;
        @(posedge clk);
        #1;

        //            name          rst rw wr  wd            rr1 rr2 u1 u2 iv irw ird  rd1           rd2           st ovf
        applyStimulus("rst_hold",    1, 0, 0, 32'h0,         5,  0,  0, 0, 0, 0,  0,  32'h0,        32'h0,        0, 0);
        applyStimulus("rst_rel",     0, 0, 0, 32'h0,         5,  0,  1, 1, 1, 0,  0,  32'h0,        32'h0,        0, 0);
        applyStimulus("wr_x0",       0, 1, 0, 32'hDEADBEEF,  0,  0,  0, 0, 0, 0,  0,  32'h0,        32'h0,        0, 0);
        applyStimulus("x0_after",    0, 0, 0, 32'h0,         0,  0,  0, 0, 0, 0,  0,  32'h0,        32'h0,        0, 0);
        applyStimulus("byp_x9",      0, 1, 9, 32'h0fdff262,  9,  5,  0, 0, 0, 0,  0,  32'h0fdff262, 32'h0,        0, 0);
        applyStimulus("stor_x9",     0, 0, 0, 32'h0,         9,  9,  1, 1, 1, 0,  0,  32'h0fdff262, 32'h0fdff262, 0, 0);
        applyStimulus("iss_x7",      0, 0, 0, 32'h0,         9,  0,  0, 0, 1, 1,  7,  32'h0fdff262, 32'h0,        0, 0);
        applyStimulus("raw_x7_a",    0, 0, 0, 32'h0,         7,  0,  1, 0, 1, 1,  10, 32'h0,        32'h0,        1, 0);
        applyStimulus("raw_x7_b",    0, 0, 0, 32'h0,         7,  0,  1, 0, 1, 1,  10, 32'h0,        32'h0,        1, 0);
        applyStimulus("wb_x7",       0, 1, 7, 32'h35c8eb66,  7,  0,  1, 0, 1, 0,  0,  32'h35c8eb66, 32'h0,        0, 0);
        applyStimulus("no_leak_x10", 0, 0, 0, 32'h0,         10, 7,  1, 1, 1, 0,  0,  32'h0,        32'h35c8eb66, 0, 0);
        applyStimulus("iss_x3_a",    0, 0, 0, 32'h0,         0,  0,  0, 0, 1, 1,  3,  32'h0,        32'h0,        0, 0);
        applyStimulus("iss_x3_b",    0, 0, 0, 32'h0,         0,  0,  0, 0, 1, 1,  3,  32'h0,        32'h0,        0, 0);
        applyStimulus("wb1_x3",      0, 1, 3, 32'h11111111,  0,  3,  0, 1, 1, 0,  0,  32'h0,        32'h11111111, 1, 0);
        applyStimulus("hold_x3",     0, 0, 0, 32'h0,         0,  3,  0, 1, 1, 0,  0,  32'h0,        32'h11111111, 1, 0);
        applyStimulus("wb2_x3",      0, 1, 3, 32'h22222222,  0,  3,  0, 1, 1, 0,  0,  32'h0,        32'h22222222, 0, 0);
        applyStimulus("clr_x3",      0, 0, 0, 32'h0,         0,  3,  0, 1, 1, 0,  0,  32'h0,        32'h22222222, 0, 0);
        applyStimulus("iss_x4",      0, 0, 0, 32'h0,         0,  0,  0, 0, 1, 1,  4,  32'h0,        32'h0,        0, 0);
        applyStimulus("incdec_x4",   0, 1, 4, 32'h44444444,  4,  0,  0, 0, 1, 1,  4,  32'h44444444, 32'h0,        0, 0);
        applyStimulus("raw_x4",      0, 0, 0, 32'h0,         4,  0,  1, 0, 1, 0,  0,  32'h44444444, 32'h0,        1, 0);
        applyStimulus("wb_x4",       0, 1, 4, 32'h55555555,  4,  0,  1, 0, 1, 0,  0,  32'h55555555, 32'h0,        0, 0);
        applyStimulus("self_dep_x6", 0, 0, 0, 32'h0,         6,  0,  1, 0, 1, 1,  6,  32'h0,        32'h0,        0, 0);
        applyStimulus("wb_x6",       0, 1, 6, 32'h66666666,  6,  6,  0, 0, 0, 0,  0,  32'h66666666, 32'h66666666, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus("sat_x2",  0, 0, 0, 32'h0,         0,  0,  0, 0, 1, 1,  2,  32'h0,        32'h0,        0, 0);
        end
        applyStimulus("raw_x2_a",    0, 0, 0, 32'h0,         2,  0,  1, 0, 1, 0,  0,  32'h0,        32'h0,        1, 1);
        applyStimulus("raw_x2_b",    0, 0, 0, 32'h0,         2,  0,  1, 0, 1, 0,  0,  32'h0,        32'h0,        1, 1);
        applyStimulus("drain_x2_a",  0, 1, 2, 32'h77777777,  2,  0,  1, 0, 1, 0,  0,  32'h77777777, 32'h0,        1, 1);
        applyStimulus("drain_x2_b",  0, 1, 2, 32'h77777777,  2,  0,  1, 0, 1, 0,  0,  32'h77777777, 32'h0,        1, 1);
        applyStimulus("wb_last_x2",  0, 1, 2, 32'h88888888,  2,  0,  1, 0, 1, 0,  0,  32'h88888888, 32'h0,        0, 1);
        applyStimulus("reiss_x2_a",  0, 0, 0, 32'h0,         0,  0,  0, 0, 1, 1,  2,  32'h0,        32'h0,        0, 1);
        applyStimulus("reiss_x2_b",  0, 0, 0, 32'h0,         0,  0,  0, 0, 1, 1,  2,  32'h0,        32'h0,        0, 1);
        applyStimulus("raw_x2_c",    0, 0, 0, 32'h0,         2,  0,  1, 0, 1, 0,  0,  32'h88888888, 32'h0,        1, 1);
        applyStimulus("rst_mid",     1, 0, 0, 32'h0,         2,  0,  1, 0, 1, 0,  0,  32'h0,        32'h0,        0, 0);
        applyStimulus("post_rst",    0, 0, 0, 32'h0,         2,  0,  1, 0, 1, 0,  0,  32'h0,        32'h0,        0, 0);

        drainBudget = 5;
        while (expQ.size() > 0 && drainBudget > 0) begin
            @(posedge clk);
            drainBudget--;
        end
        if (expQ.size() > 0) begin
            errorCount++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/id_regfile_sb.md
Name: id_regfile_sb

Overview:
- ID-stage register file with an in-flight-write scoreboard.
- Receives the writeback stage's outputs (WriteData_ID, WriteRegister_ID, RegWrite_ID) and commits them to a 32x32 register array.
- Serves two combinational read ports with same-cycle write-to-read bypass.
- Tracks outstanding writes per register so that ID stalls on RAW hazards until the producing writeback arrives.

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of architectural registers (x0 hardwired to zero)
CNT_W, 2, width of the per-register outstanding-write counter (max 2^CNT_W-1 in flight)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
RegWrite_ID  input  1  writeback enable from WB stage
WriteRegister_ID  input  5  writeback destination register index
WriteData_ID  input  XLEN  writeback data
ReadReg1  input  5  source register 1 index
ReadReg2  input  5  source register 2 index
UsesRs1  input  1  current ID instruction reads ReadReg1
UsesRs2  input  1  current ID instruction reads ReadReg2
IssueValid  input  1  ID holds a valid instruction attempting to issue
IssueRegWrite  input  1  issuing instruction will write a register
IssueRd  input  5  destination of issuing instruction
ReadData1  output  XLEN  source 1 value
ReadData2  output  XLEN  source 2 value
Stall  output  1  RAW hazard; ID must hold, issue not accepted
SbOverflow  output  1  sticky: increment attempted on a saturated counter

Behaviour:
- Reset (async, active-high):
  - x1..x31 <= 0; all counters <= 0; SbOverflow <= 0.
  - Hence ReadData1/2 = 0 and Stall = 0 while reset is held.
  - Reset asserted mid-operation discards all pending counts immediately.
- Write:
  - On posedge, if RegWrite_ID && WriteRegister_ID != 0, then reg[WriteRegister_ID] <= WriteData_ID.
  - Writes to x0 are ignored.
- Read (combinational, zero latency):
  - ReadDataN = 0 if ReadRegN == 0.
  - Else ReadDataN = WriteData_ID if RegWrite_ID && WriteRegister_ID == ReadRegN (bypass).
  - Else ReadDataN = reg[ReadRegN].
- Issue acceptance: issue_fire = IssueValid && !Stall.
- Counter update per register r != 0, at posedge:
  - inc = issue_fire && IssueRegWrite && IssueRd == r.
  - dec = RegWrite_ID && WriteRegister_ID == r && cnt[r] != 0.
  - inc && dec: cnt unchanged.
  - inc only: cnt+1; if cnt == max, cnt holds and SbOverflow <= 1 (sticky until reset).
  - dec only: cnt-1.
  - A writeback to a register with cnt == 0 is an untracked write: data is committed, cnt stays 0.
- Effective busy:
  - busy(r) = r != 0 && (cnt[r] - (RegWrite_ID && WriteRegister_ID == r && cnt[r] != 0)) != 0.
  - The last outstanding write arriving this cycle clears the hazard in the same cycle, and its data is supplied by the bypass.
- Stall = IssueValid && ((UsesRs1 && busy(ReadReg1)) || (UsesRs2 && busy(ReadReg2))).
  - Purely combinational; no registered delay.
- Self-dependence: an instruction with IssueRd equal to its own source checks the counts before its own increment, so it does not stall on itself.
- x0: never busy, never counted, always reads 0.

Decomposition:
- Package rf_pkg holds:
  - localparams XLEN, NUM_REGS, REG_IDX_W=5, CNT_W.
  - typedef reg_idx_t (5 bits), xword_t (XLEN bits), sb_cnt_t (CNT_W bits).
- Sub-module rf_scoreboard contains:
  - the counter array, inc/dec logic, busy evaluation, Stall and SbOverflow.
  - Its inputs: the issue signals, the writeback index/enable, and the two read indices with their use flags.
- The top level contains the storage array and the bypass muxes.

Test Plan:
- Reset then read x5, x0 -> ReadData1 = 0, ReadData2 = 0, Stall = 0, SbOverflow = 0. Write x0 = 0xDEADBEEF -> x0 still reads 0.
- WB writes x9 = 0x0fdff262 while ReadReg1 = 9 in the same cycle -> ReadData1 = 0x0fdff262 combinationally (bypass). Next cycle, with RegWrite_ID = 0 -> still 0x0fdff262 from storage.
- Issue rd = 7 (IssueRegWrite = 1), then next cycle IssueValid with UsesRs1 = 1, ReadReg1 = 7 -> Stall = 1 each cycle until WB writes x7 = 0x35c8eb66. That cycle: Stall = 0 and ReadData1 = 0x35c8eb66.
- Issue rd = 3 twice (cnt = 2), WB x3 once -> a reader of x3 still stalls. On the second WB x3: Stall drops in that cycle and cnt returns to 0.
- Same cycle: issue rd = 4 and WB x4 with cnt = 1 -> cnt stays 1. A reader of x4 next cycle stalls.
- Four issues to rd = 2 with no WB (CNT_W = 2) -> cnt saturates at 3 and SbOverflow = 1. Assert reset mid-stall -> Stall = 0 and SbOverflow = 0 immediately.
